// File: rtl/bt6_elevator_ctrl_pkg.sv
// Shared floor encodings, motion codes and the one-step move rule for the elevator controller.
// Pure definitions; no state, no flow control.
package bt6_elevator_ctrl_pkg;

  typedef enum logic [1:0] {
    FLOOR_G = 2'b00,
    FLOOR_1 = 2'b01,
    FLOOR_2 = 2'b10,
    FLOOR_3 = 2'b11
  } floor_e;

  localparam logic [2:0] Y_UP   = 3'b100;
  localparam logic [2:0] Y_DOWN = 3'b010;
  localparam logic [2:0] Y_STOP = 3'b001;

  // One floor toward the request; saturates naturally because a request
  // beyond the end floors cannot be encoded in 2 bits.
  function automatic floor_e next_floor(input floor_e cur, input logic [1:0] req);
    floor_e nxt;
    nxt = cur;
    if (req > cur) begin
      nxt = floor_e'(cur + 2'd1);
    end else if (req < cur) begin
      nxt = floor_e'(cur - 2'd1);
    end
    return nxt;
  endfunction

  function automatic logic [2:0] motion_code(input floor_e cur, input logic [1:0] req);
    logic [2:0] code;
    code = Y_STOP;
    if (req > cur) begin
      code = Y_UP;
    end else if (req < cur) begin
      code = Y_DOWN;
    end
    return code;
  endfunction

endpackage

// File: rtl/bt6_elevator_ctrl.sv
// Four-floor elevator FSM: moves one floor per edge toward R and reports the move one-hot on Y.
// Latency 1 edge from R to State/Y, both registered; no handshake, R is sampled every edge.
module bt6_elevator_ctrl
  import bt6_elevator_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] R,
  output logic [2:0] Y
);

  floor_e     State;
  floor_e     state_nxt;
  logic [2:0] y_nxt;

  always_comb begin
    state_nxt = State;
    y_nxt     = Y_STOP;
    state_nxt = next_floor(State, R);
    y_nxt     = motion_code(State, R);
  end

  // Reset jumps straight to G rather than descending floor by floor.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      State <= FLOOR_G;
      Y     <= Y_STOP;
    end else begin
      State <= state_nxt;
      Y     <= y_nxt;
    end
  end

endmodule

// File: tb/tb_bt6_elevator_ctrl.sv
// Directed-vector bench for bt6_elevator_ctrl with hand-computed floor and motion expectations.
module tb_bt6_elevator_ctrl;

  logic       clk;
  logic       rst_n;
  logic [1:0] R;
  logic [2:0] Y;

  int n_chk = 0;
  int n_err = 0;

  bt6_elevator_ctrl uut (
    .clk  (clk),
    .rst_n(rst_n),
    .R    (R),
    .Y    (Y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Apply rst_n/R, take one edge, then check floor, motion code and one-hotness.
  task automatic step(input string tag, input logic rn, input logic [1:0] r,
                      input logic [1:0] es, input logic [2:0] ey);
    rst_n = rn;
    R     = r;
    @(posedge clk);
    #1;
    chk({tag, ".state"}, 8'(uut.State), 8'(es));
    chk({tag, ".y"}, 8'(Y), 8'(ey));
    chk({tag, ".onehot"}, 8'($countones(Y)), 8'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    R     = 2'd3;
    #2;

    // reset held two edges with a pending request for floor 3
    step("rst0", 1'b0, 2'd3, 2'b00, 3'b001);
    step("rst1", 1'b0, 2'd3, 2'b00, 3'b001);

    // G -> 1 then hold
    step("up1_a", 1'b1, 2'd1, 2'b01, 3'b100);
    step("up1_b", 1'b1, 2'd1, 2'b01, 3'b001);
    step("up1_c", 1'b1, 2'd1, 2'b01, 3'b001);

    // request 3 for one edge, then back to G
    step("mix_a", 1'b1, 2'd3, 2'b10, 3'b100);
    step("mix_b", 1'b1, 2'd0, 2'b01, 3'b010);
    step("mix_c", 1'b1, 2'd0, 2'b00, 3'b010);
    step("mix_d", 1'b1, 2'd0, 2'b00, 3'b001);

    // immediate reversals from G
    step("rev_a", 1'b1, 2'd2, 2'b01, 3'b100);
    step("rev_b", 1'b1, 2'd1, 2'b01, 3'b001);
    step("rev_c", 1'b1, 2'd3, 2'b10, 3'b100);
    step("rev_d", 1'b1, 2'd2, 2'b10, 3'b001);
    step("rev_e", 1'b1, 2'd0, 2'b01, 3'b010);

    // climb to the top and saturate there
    step("top_a", 1'b1, 2'd3, 2'b10, 3'b100);
    step("top_b", 1'b1, 2'd3, 2'b11, 3'b100);
    step("top_c", 1'b1, 2'd3, 2'b11, 3'b001);
    step("top_d", 1'b1, 2'd3, 2'b11, 3'b001);

    // full descent and saturate at G
    step("dn_a", 1'b1, 2'd0, 2'b10, 3'b010);
    step("dn_b", 1'b1, 2'd0, 2'b01, 3'b010);
    step("dn_c", 1'b1, 2'd0, 2'b00, 3'b010);
    step("dn_d", 1'b1, 2'd0, 2'b00, 3'b001);
    step("dn_e", 1'b1, 2'd0, 2'b00, 3'b001);

    // reset mid-travel at floor 2 returns to G in a single edge
    step("mrst_a", 1'b1, 2'd3, 2'b01, 3'b100);
    step("mrst_b", 1'b1, 2'd3, 2'b10, 3'b100);
    step("mrst_c", 1'b0, 2'd3, 2'b00, 3'b001);
    step("mrst_d", 1'b1, 2'd3, 2'b01, 3'b100);

    // reset from the top floor as well
    step("trst_a", 1'b1, 2'd3, 2'b10, 3'b100);
    step("trst_b", 1'b1, 2'd3, 2'b11, 3'b100);
    step("trst_c", 1'b0, 2'd2, 2'b00, 3'b001);
    step("trst_d", 1'b1, 2'd2, 2'b01, 3'b100);
    step("trst_e", 1'b1, 2'd0, 2'b00, 3'b010);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bt6_elevator_ctrl.md
# bt6_elevator_ctrl

Four-floor (G, 1, 2, 3) elevator controller FSM. Each clock it compares the requested floor `R` with the car's current floor, held in the internal register `State`, and moves the car one floor toward the request. It reports the motion taken in that cycle on the one-hot output `Y`. It is a leaf block driven by a floor-request source, and its floor register can be probed hierarchically by benches.

## Interface
- No parameters; floor count fixed at 4 (2-bit floor code, G = 0).
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `R`  input  2  requested floor (0 = G, 1, 2, 3); sampled every rising edge, no handshake.
- `Y`  output  3  registered one-hot motion status:
  - `Y[2]` = moved up this cycle.
  - `Y[1]` = moved down this cycle.
  - `Y[0]` = stopped at the requested floor.
- Internal `State` (2 bits): current floor. Must keep exactly this name, since benches probe `uut.State`.

## Operation
- FSM states: FLOOR_G (00), FLOOR_1 (01), FLOOR_2 (10), FLOOR_3 (11). `State` holds the state code.
- At each rising edge with `rst_n` = 1:
  - If `R` > `State`: `State` becomes `State` + 1 and `Y` becomes 100.
  - If `R` < `State`: `State` becomes `State` − 1 and `Y` becomes 010.
  - If `R` = `State`: `State` is unchanged and `Y` becomes 001.
- Movement is one floor per cycle. No skipping floors, no request queueing. Only the current `R` value matters.
- A request change mid-travel is obeyed immediately on the next edge, so direction can reverse at once.
- Saturation: `State` never wraps. Floor 3 with `R` = 3 gives 001; G with `R` = 0 gives 001. 11→00 and 00→11 are impossible.
- `Y` is always exactly one-hot. 000 and multi-hot values are illegal and must never appear.

## Timing
- Reset: on an edge with `rst_n` = 0, `State` becomes 00 and `Y` becomes 001, regardless of `R`.
- Reset asserted mid-travel returns the car to G in one edge. This is not a stepped descent.
- Latency: a new `R` affects `State`/`Y` at the first rising edge after it is applied.
- Travel from floor a to floor b takes |b − a| edges with `Y` = 100 or 010. The next edge with `R` unchanged gives 001.
- `Y` and `State` are both registered and change only on clock edges. `Y` has no combinational path from `R`.

## Structure
- Shared package: floor encodings (`FLOOR_G`..`FLOOR_3`) and `Y` codes (`Y_UP` = 100, `Y_DOWN` = 010, `Y_STOP` = 001).
- Single module: one `always @(posedge clk)` block handles both `State` and `Y`. A compare/next-floor function may be factored out.
- No sub-module is needed.

## Test plan
- Reset: hold `rst_n` = 0 for 2 edges with `R` = 3 → `State` = 00, `Y` = 001.
- From G, hold `R` = 1 for 3 edges → `State` 01/01/01, `Y` 100/001/001.
- From 01, `R` = 3 for 1 edge then `R` = 0 for 2 edges → `State` 10, 01, 00; `Y` 100, 010, 010. One more edge with `R` = 0 → `Y` = 001.
- Reversal: from 00, apply `R` = 2, 1, 3, 2, 0, one edge each → `State` 01, 01, 10, 10, 01; `Y` 100, 001, 100, 001, 010.
- Saturation: at 11 with `R` = 3 → `State` stays 11, `Y` = 001. At 00 with `R` = 0 → `Y` = 001.
- Mid-travel reset: moving 00→11, assert `rst_n` = 0 when `State` = 10 → next edge `State` = 00, `Y` = 001. Check that `Y` stays one-hot throughout every run.
